mem_access_stage: RTL

- Pipeline stage directly downstream of the execute stage. It holds the EX/MEM pipeline register and drives the data-memory request/ready handshake.
- Resolves the branch decision (pc_src) and fills the MEM/WB pipeline register consumed by write-back.
- Stalls the upstream pipeline while a multi-cycle memory access is outstanding, and flags misaligned or timed-out accesses.

---
 rtl/pipeline_pkg.sv | 48 ++++
 rtl/mem_access_stage_if.sv | 19 +
 rtl/mem_access_stage_mem_wait_timer.sv | 30 +++
 rtl/mem_access_stage.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared types for the memory-access stage: FSM states, pipeline register
// layouts and the alignment helper.
package pipeline_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FAULT = 2'd2
  } mem_state_t;

  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic [4:0]  write_register;
    logic [31:0] branch_address;
    logic        zero;
    logic        branch;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        mem_to_reg;
  } exmem_t;

  typedef struct packed {
    logic [31:0] read_data;
    logic [31:0] alu_result;
    logic [4:0]  write_register;
    logic        reg_write;
    logic        mem_to_reg;
  } memwb_t;

  function automatic logic is_aligned(input logic [31:0] addr);
    return (addr[1:0] & WORD_ALIGN_MASK) == 2'b00;
  endfunction

  function automatic memwb_t memwb_from_exmem(input exmem_t e, input logic [31:0] rdata);
    memwb_t m;
    m.read_data      = rdata;
    m.alu_result     = e.alu_result;
    m.write_register = e.write_register;
    m.reg_write      = e.reg_write;
    m.mem_to_reg     = e.mem_to_reg;
    return m;
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/ready bus between the memory-access stage and memory.
interface mem_access_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ready
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ready
  );
endinterface

// File: rtl/mem_access_stage_mem_wait_timer.sv
// Saturating wait counter for an outstanding memory access; flags when the
// programmed number of wait cycles has elapsed.
module mem_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic count,
  input  logic clear,
  output logic timeout
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES);

  logic [7:0] cnt;

  // Count wait cycles, saturating at the top of the range; clear wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count && cnt != '1) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign timeout = (cnt == LIMIT);

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: EX/MEM register, data-memory handshake, branch
// resolution, MEM/WB register and upstream stall generation.
module mem_access_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         alu_result_ex,
  input  logic [31:0]         write_data_ex,
  input  logic [4:0]          write_register_ex,
  input  logic [31:0]         branch_address_ex,
  input  logic                zero_ex,
  input  logic                ctrl_branch_ex,
  input  logic                ctrl_memRead_ex,
  input  logic                ctrl_memWrite_ex,
  input  logic                ctrl_regWrite_ex,
  input  logic                ctrl_memToReg_ex,
  mem_access_stage_if.master  dmem,
  output logic                stall,
  output logic                pc_src,
  output logic [31:0]         branch_target,
  output logic                mem_error,
  output logic [31:0]         read_data_mem_wb,
  output logic [31:0]         alu_result_mem_wb,
  output logic [4:0]          write_register_mem_wb,
  output logic                ctrl_regWrite_mem_wb,
  output logic                ctrl_memToReg_mem_wb
);

  exmem_t     exmem, exmem_in;
  memwb_t     memwb, memwb_next;
  mem_state_t state, state_next;
  logic       mem_op, aligned, req, err_set;
  logic       tmr_count, tmr_clear, tmr_timeout;
  logic [31:0] load_data;

  assign exmem_in = '{
    alu_result:     alu_result_ex,
    write_data:     write_data_ex,
    write_register: write_register_ex,
    branch_address: branch_address_ex,
    zero:           zero_ex,
    branch:         ctrl_branch_ex,
    mem_read:       ctrl_memRead_ex,
    mem_write:      ctrl_memWrite_ex,
    reg_write:      ctrl_regWrite_ex,
    mem_to_reg:     ctrl_memToReg_ex
  };

  assign mem_op    = exmem.mem_read | exmem.mem_write;
  assign aligned   = is_aligned(exmem.alu_result);
  assign load_data = exmem.mem_write ? '0 : dmem.dmem_rdata;

  mem_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .count   (tmr_count),
    .clear   (tmr_clear),
    .timeout (tmr_timeout)
  );

  // Access sequencing: decide request, stall, MEM/WB contents and next state.
  // MEM/WB defaults to an all-zero bubble; only completed or non-memory
  // instructions overwrite it.
  always_comb begin
    state_next = state;
    req        = 1'b0;
    stall      = 1'b0;
    err_set    = 1'b0;
    tmr_count  = 1'b0;
    tmr_clear  = 1'b0;
    memwb_next = '0;
    case (state)
      IDLE: begin
        if (!mem_op) begin
          memwb_next = memwb_from_exmem(exmem, '0);
        end else if (!aligned) begin
          err_set = 1'b1;
        end else begin
          req = 1'b1;
          if (dmem.dmem_ready) begin
            memwb_next = memwb_from_exmem(exmem, load_data);
          end else begin
            stall      = 1'b1;
            tmr_count  = 1'b1;
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        req = 1'b1;
        if (dmem.dmem_ready) begin
          memwb_next = memwb_from_exmem(exmem, load_data);
          tmr_clear  = 1'b1;
          state_next = IDLE;
        end else if (tmr_timeout) begin
          stall      = 1'b1;
          err_set    = 1'b1;
          tmr_clear  = 1'b1;
          state_next = FAULT;
        end else begin
          stall     = 1'b1;
          tmr_count = 1'b1;
        end
      end
      FAULT: begin
        // EX/MEM still holds the aborted access here; it is dropped.
        if (!mem_op) begin
          memwb_next = memwb_from_exmem(exmem, '0);
        end
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Pipeline registers, FSM state and sticky error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exmem     <= '0;
      memwb     <= '0;
      state     <= IDLE;
      mem_error <= 1'b0;
    end else begin
      if (!stall) begin
        exmem <= exmem_in;
      end
      memwb <= memwb_next;
      state <= state_next;
      if (err_set) begin
        mem_error <= 1'b1;
      end
    end
  end

  assign dmem.dmem_req   = req;
  assign dmem.dmem_we    = exmem.mem_write;
  assign dmem.dmem_addr  = exmem.alu_result;
  assign dmem.dmem_wdata = exmem.write_data;

  assign pc_src        = exmem.branch & exmem.zero;
  assign branch_target = exmem.branch_address;

  assign read_data_mem_wb      = memwb.read_data;
  assign alu_result_mem_wb     = memwb.alu_result;
  assign write_register_mem_wb = memwb.write_register;
  assign ctrl_regWrite_mem_wb  = memwb.reg_write;
  assign ctrl_memToReg_mem_wb  = memwb.mem_to_reg;

endmodule
